systolic_pe: RTL and testbench
==============================

SYSTOLIC_PE -- requirements
Module: systolic_pe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed operand width.
REQ-002 SHALL have parameter ACC_W, default 24, signed accumulator/result width; ACC_W >= 2*DATA_W is required.
REQ-003 SHALL have parameter SATURATE, default 1; 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous tile clear.
REQ-007 SHALL have port mode  input  1  0 = output-stationary (OS), 1 = weight-stationary (WS); quasi-static, changed only together with clear.
REQ-008 SHALL have port valid_in  input  1  a_in/b_in (and psum_in in WS) valid this cycle.
REQ-009 SHALL have ports a_in and b_in, each input DATA_W, signed operands.
REQ-010 SHALL have port psum_in  input  ACC_W  signed partial sum from upstream PE (WS only).
REQ-011 SHALL have port w_load  input  1  load b_in into the weight register.
REQ-012 SHALL have port flush  input  1  OS: emit accumulator and restart.
REQ-013 SHALL have ports a_out and b_out, each output DATA_W, registered operand forwarding.
REQ-014 SHALL have port valid_out  output  1  registered copy of valid_in.
REQ-015 SHALL have port c_out  output  ACC_W  signed result.
REQ-016 SHALL have port c_valid  output  1  c_out valid, one-cycle pulse.
REQ-017 SHALL have port ovf  output  1  sticky overflow flag.

Function
REQ-018 SHALL register a_out<=a_in, b_out<=b_in and valid_out<=valid_in every non-reset, non-clear cycle, in both modes (1-cycle latency, always forwarded).
REQ-019 SHALL form product p = a_in*b_in (OS) or a_in*weight (WS), 2*DATA_W signed, sign-extended to ACC_W before addition.
REQ-020 OS: when valid_in=1 and flush=0, the accumulator SHALL take acc+p at the next edge; when valid_in=0 and flush=0, it SHALL hold.
REQ-021 OS: on flush=1, c_out SHALL take acc+p (valid_in=1) or acc (valid_in=0), c_valid=1 on the next cycle, and acc SHALL take 0.
REQ-022 OS: c_valid SHALL be 0 in every cycle not following a flush; c_out SHALL hold its last value.
REQ-023 WS: when valid_in=1, c_out SHALL take psum_in+p and c_valid SHALL take 1 at the next edge (1-cycle latency); when valid_in=0, c_valid SHALL take 0. The accumulator and flush SHALL be ignored in WS.
REQ-024 WS: when w_load=1, weight SHALL take b_in; when valid_in and w_load are both 1, p SHALL use the old weight.
REQ-025 In OS, w_load SHALL still update weight; it has no other effect.
REQ-026 Every ACC_W addition SHALL detect signed overflow; on overflow ovf SHALL set and stay set until rst or clear.
REQ-027 With SATURATE=1, an overflowing result SHALL clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) by sign; with SATURATE=0, it SHALL wrap.
REQ-028 Priority SHALL be rst > clear > normal operation; clear SHALL zero acc, c_out, c_valid, ovf, a_out, b_out and valid_out, and SHALL retain weight.

Reset
REQ-029 Synchronous rst SHALL zero every register: acc, weight, c_out, c_valid, ovf, a_out, b_out and valid_out.
REQ-030 rst asserted mid-accumulation or mid-flush SHALL discard the work in progress; no c_valid pulse SHALL follow it.

Structure
REQ-031 Package pe_pkg SHALL hold the mode encoding constants (MODE_OS=0, MODE_WS=1) and the saturation-limit helper functions.
REQ-032 A sub-module pe_sat_add (ACC_W-parameterised signed adder with sum, overflow and SATURATE clamp) SHALL be used for both the OS and WS additions.

Verification (DATA_W=8)
REQ-033 OS, ACC_W=24: valid a/b pairs (3,4), (-2,5), (7,7), flush on the third pair -> c_out=51, c_valid one cycle, next acc=0.
REQ-034 OS, ACC_W=16, SATURATE=1: two valid (-128,-128) pairs, flush on the second -> c_out=32767, ovf=1, ovf held until clear.
REQ-035 Same as REQ-034 with SATURATE=0 -> c_out=-32768, ovf=1.
REQ-036 WS: w_load b_in=-3 then valid a_in=10, psum_in=100 -> c_out=70 one cycle later; w_load b_in=5 with valid a_in=2 in the same cycle -> product uses -3.
REQ-037 a_in=9, b_in=-1, valid_in=1 -> a_out=9, b_out=-1, valid_out=1 exactly one cycle later, in both modes.
REQ-038 clear during OS accumulation, and rst issued in the flush cycle -> acc=0, c_valid stays 0, weight retained after clear and zeroed after rst.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the systolic processing element.
//   pe_mode_e        : dataflow mode encoding (MODE_OS = 0, MODE_WS = 1)
//   sat_max/sat_min  : largest/smallest signed value of a given width,
//                      returned 64 bits wide for the caller to truncate.
package pe_pkg;

    typedef enum logic {
        MODE_OS = 1'b0,
        MODE_WS = 1'b1
    } pe_mode_e;

    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/pe_sat_add.sv
// pe_sat_add: combinational ACC_W-bit signed adder with overflow detection.
//   a, b : signed addends
//   sum  : a+b, clamped to the signed range when SATURATE=1, wrapped otherwise
//   ovf  : signed overflow of a+b
module pe_sat_add
    import pe_pkg::*;
#(
    parameter int ACC_W    = 24,
    parameter int SATURATE = 1
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

    logic signed [ACC_W-1:0] raw;

    always_comb begin
        raw = a + b;
        // Overflow only when both addends share a sign the result lacks.
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
        sum = raw;
        if (ovf && (SATURATE != 0)) begin
            sum = a[ACC_W-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/systolic_pe.sv
// systolic_pe: one multiply-accumulate cell of a systolic array.
//   clk, rst        : clock, synchronous active-high reset
//   clear           : synchronous tile clear (weight is kept)
//   mode            : 0 output-stationary, 1 weight-stationary
//   valid_in        : a_in/b_in (and psum_in in WS) valid
//   a_in, b_in      : signed operands
//   psum_in         : upstream partial sum (WS)
//   w_load          : load b_in into the weight register
//   flush           : OS: emit accumulator and restart
//   a_out, b_out    : operands forwarded with one cycle latency
//   valid_out       : valid_in forwarded with one cycle latency
//   c_out, c_valid  : result and its one-cycle valid pulse
//   ovf             : sticky overflow flag
module systolic_pe
    import pe_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter int SATURATE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     mode,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    input  logic signed [ACC_W-1:0]  psum_in,
    input  logic                     w_load,
    input  logic                     flush,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [DATA_W-1:0] b_out,
    output logic                     valid_out,
    output logic signed [ACC_W-1:0]  c_out,
    output logic                     c_valid,
    output logic                     ovf
);

    pe_mode_e                  mode_e;
    logic signed [DATA_W-1:0]  mul_b;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   add_a, add_b, add_sum;
    logic                      add_ovf;

    logic signed [ACC_W-1:0]   acc_d, acc_q, c_out_d, c_out_q;
    logic signed [DATA_W-1:0]  weight_d, weight_q, a_d, a_q, b_d, b_q;
    logic                      c_valid_d, c_valid_q, ovf_d, ovf_q, v_d, v_q;

    // A single adder serves both modes: upstream psum in WS, the local
    // accumulator in OS. An invalid cycle adds zero so an OS flush without
    // data simply emits the accumulator.
    always_comb begin
        mode_e = pe_mode_e'(mode);
        mul_b  = (mode_e == MODE_WS) ? weight_q : b_in;
        prod   = (2*DATA_W)'(a_in) * (2*DATA_W)'(mul_b);
        add_a  = (mode_e == MODE_WS) ? psum_in : acc_q;
        add_b  = valid_in ? ACC_W'(prod) : '0;
    end

    pe_sat_add #(
        .ACC_W   (ACC_W),
        .SATURATE(SATURATE)
    ) u_add (
        .a  (add_a),
        .b  (add_b),
        .sum(add_sum),
        .ovf(add_ovf)
    );

    always_comb begin
        acc_d     = acc_q;
        weight_d  = w_load ? b_in : weight_q;
        c_out_d   = c_out_q;
        c_valid_d = 1'b0;
        ovf_d     = ovf_q;
        a_d       = a_in;
        b_d       = b_in;
        v_d       = valid_in;

        if (mode_e == MODE_WS) begin
            if (valid_in) begin
                c_out_d   = add_sum;
                c_valid_d = 1'b1;
                ovf_d     = ovf_q | add_ovf;
            end
        end else if (flush) begin
            c_out_d   = add_sum;
            c_valid_d = 1'b1;
            acc_d     = '0;
            ovf_d     = ovf_q | add_ovf;
        end else if (valid_in) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_ovf;
        end

        if (clear) begin
            acc_d     = '0;
            weight_d  = weight_q;
            c_out_d   = '0;
            c_valid_d = 1'b0;
            ovf_d     = 1'b0;
            a_d       = '0;
            b_d       = '0;
            v_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            weight_q  <= '0;
            c_out_q   <= '0;
            c_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            v_q       <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            weight_q  <= weight_d;
            c_out_q   <= c_out_d;
            c_valid_q <= c_valid_d;
            ovf_q     <= ovf_d;
            a_q       <= a_d;
            b_q       <= b_d;
            v_q       <= v_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign valid_out = v_q;
    assign c_out     = c_out_q;
    assign c_valid   = c_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Bench for systolic_pe: three instances share one stimulus stream
// (ACC_W=24 saturating, ACC_W=16 saturating, ACC_W=16 wrapping). Expected
// results are queued when stimulus is issued; monitors pop on each c_valid.
module tb_systolic_pe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, clear, mode, valid_in, w_load, flush;
    logic signed [7:0]  a_in, b_in;
    logic signed [23:0] psum;

    logic signed [7:0]  a24, b24, a16s, b16s, a16w, b16w;
    logic               vo24, vo16s, vo16w;
    logic signed [23:0] c24;
    logic signed [15:0] c16s, c16w;
    logic               cv24, cv16s, cv16w, ovf24, ovf16s, ovf16w;

    systolic_pe #(.DATA_W(8), .ACC_W(24), .SATURATE(1)) dut24 (
        .clk(clk), .rst(rst), .clear(clear), .mode(mode), .valid_in(valid_in),
        .a_in(a_in), .b_in(b_in), .psum_in(psum), .w_load(w_load), .flush(flush),
        .a_out(a24), .b_out(b24), .valid_out(vo24), .c_out(c24), .c_valid(cv24), .ovf(ovf24));

    systolic_pe #(.DATA_W(8), .ACC_W(16), .SATURATE(1)) dut16s (
        .clk(clk), .rst(rst), .clear(clear), .mode(mode), .valid_in(valid_in),
        .a_in(a_in), .b_in(b_in), .psum_in(psum[15:0]), .w_load(w_load), .flush(flush),
        .a_out(a16s), .b_out(b16s), .valid_out(vo16s), .c_out(c16s), .c_valid(cv16s), .ovf(ovf16s));

    systolic_pe #(.DATA_W(8), .ACC_W(16), .SATURATE(0)) dut16w (
        .clk(clk), .rst(rst), .clear(clear), .mode(mode), .valid_in(valid_in),
        .a_in(a_in), .b_in(b_in), .psum_in(psum[15:0]), .w_load(w_load), .flush(flush),
        .a_out(a16w), .b_out(b16w), .valid_out(vo16w), .c_out(c16w), .c_valid(cv16w), .ovf(ovf16w));

    int checks = 0;
    int errors = 0;
    int q24[$], q16s[$], q16w[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int e24, input int e16s, input int e16w);
        q24.push_back(e24);
        q16s.push_back(e16s);
        q16w.push_back(e16w);
    endtask

    task automatic idle();
        valid_in = 1'b0; w_load = 1'b0; flush = 1'b0; clear = 1'b0; rst = 1'b0;
        a_in = '0; b_in = '0; psum = '0;
    endtask

    // Advance one edge; outputs are then stable at edge+1.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic op(input logic v, input int a, input int b, input int ps,
                      input logic wl, input logic fl);
        valid_in = v; a_in = 8'(a); b_in = 8'(b); psum = 24'(ps);
        w_load = wl; flush = fl;
    endtask

    // Scoreboard monitors, sampling on the falling edge.
    always @(negedge clk) begin
        if (cv24) begin
            if (q24.size() == 0) chk("c24_unexpected", 1, 0);
            else chk("c24", c24, q24.pop_front());
        end
        if (cv16s) begin
            if (q16s.size() == 0) chk("c16s_unexpected", 1, 0);
            else chk("c16s", c16s, q16s.pop_front());
        end
        if (cv16w) begin
            if (q16w.size() == 0) chk("c16w_unexpected", 1, 0);
            else chk("c16w", c16w, q16w.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        mode = 1'b0;
        rst  = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        chk("rst_c_out", c24, 0);
        chk("rst_c_valid", cv24, 0);
        chk("rst_ovf", ovf24, 0);
        chk("rst_a_out", a24, 0);
        chk("rst_valid_out", vo24, 0);

        // OS: 3*4 + (-2)*5 + 7*7 = 51, flush on third pair
        op(1, 3, 4, 0, 0, 0);   tick();
        op(1, -2, 5, 0, 0, 0);  tick();
        op(1, 7, 7, 0, 0, 1);   push(51, 51, 51); tick();
        op(1, 1, 1, 0, 0, 1);   push(1, 1, 1);    tick();
        tick();
        chk("os_c_hold", c24, 1);
        chk("os_c_valid_low", cv24, 0);

        // OS overflow: 16384 + 16384
        op(1, -128, -128, 0, 0, 0); tick();
        op(1, -128, -128, 0, 0, 1); push(32768, 32767, -32768); tick();
        chk("ovf24_none", ovf24, 0);
        chk("ovf16s_set", ovf16s, 1);
        chk("ovf16w_set", ovf16w, 1);
        tick(); tick();
        chk("ovf16s_sticky", ovf16s, 1);
        chk("ovf16w_sticky", ovf16w, 1);
        clear = 1'b1; tick();
        chk("clr_ovf16s", ovf16s, 0);
        chk("clr_ovf16w", ovf16w, 0);
        chk("clr_c_out", c16s, 0);

        // Hold when invalid, flush without data
        op(1, 2, 3, 0, 0, 0); tick();
        tick();
        op(0, 0, 0, 0, 0, 1); push(6, 6, 6); tick();
        tick();

        // Forwarding in OS; this pair also accumulates -9, then clear drops it
        op(1, 9, -1, 0, 0, 0); tick();
        chk("os_a_out", a24, 9);
        chk("os_b_out", b24, -1);
        chk("os_valid_out", vo24, 1);
        clear = 1'b1; tick();
        chk("clr_a_out", a24, 0);
        chk("clr_valid_out", vo24, 0);
        op(0, 0, 0, 0, 0, 1); push(0, 0, 0); tick();
        tick();

        // WS
        clear = 1'b1; mode = 1'b1; tick();
        op(0, 0, -3, 0, 1, 0);    tick();
        op(1, 10, 0, 100, 0, 0);  push(70, 70, 70); tick();
        op(1, 2, 5, 0, 1, 0);     push(-6, -6, -6); tick();
        op(1, 9, -1, 0, 0, 0);    push(45, 45, 45); tick();
        chk("ws_a_out", a24, 9);
        chk("ws_b_out", b24, -1);
        chk("ws_valid_out", vo24, 1);
        op(0, 0, 0, 0, 0, 1);     tick();
        chk("ws_flush_ignored", cv24, 0);
        op(1, 10, 0, 32767, 0, 0); push(32817, 32767, -32719); tick();
        chk("ws_ovf24", ovf24, 0);
        chk("ws_ovf16s", ovf16s, 1);
        chk("ws_ovf16w", ovf16w, 1);
        clear = 1'b1; tick();
        op(1, 1, 0, 0, 0, 0);     push(5, 5, 5); tick();
        tick();

        // rst in the flush cycle discards the result and the weight
        clear = 1'b1; mode = 1'b0; tick();
        op(1, 4, 4, 0, 0, 0); tick();
        op(1, 4, 4, 0, 0, 1); rst = 1'b1; tick();
        chk("rst_flush_c_valid", cv24, 0);
        tick(); tick();
        chk("rst_flush_c_out", c24, 0);
        clear = 1'b1; mode = 1'b1; tick();
        op(1, 7, 0, 1, 0, 0); push(1, 1, 1); tick();
        tick(); tick(); tick();

        chk("q24_drained", q24.size(), 0);
        chk("q16s_drained", q16s.size(), 0);
        chk("q16w_drained", q16w.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
